td4_clock_ctrl: RTL and testbench

Run-control and input-conditioning front end for the TD4 CPU core. Sits directly upstream of the core: it turns the board's raw step button, mode selector and DIP switches into a one-cycle CPU clock-enable pulse and a clean, debounced 4-bit `sw` value. It supports halt, single-step, slow and fast run modes, and counts issued steps for debug display.

---
 rtl/td4_clock_ctrl.sv | 148 ++++++++++++++
 tb/tb_td4_clock_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/td4_clock_ctrl.sv
// td4_clock_ctrl: run-control front end for the TD4 core.
// Synchronizes and debounces the step button and DIP switches, tracks the
// run mode, and issues a one-cycle cpu_en pulse in step, slow or fast mode.
module td4_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DIV_SLOW        = 12500000,
    parameter int DIV_FAST        = 125000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       step_btn,
    input  logic [3:0] sw_raw,
    output logic       cpu_en,
    output logic [3:0] sw,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_FAST = 2'b11
    } run_mode_e;

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NDB     = 5;  // bits 3:0 = switches, bit 4 = step button

    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]                mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic [NDB-1:0]            in_s1_q, in_s1_d, in_s2_q, in_s2_d;
    logic [NDB-1:0]            deb_q, deb_d;
    logic [NDB-1:0][DB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic                      btn_prev_q, btn_prev_d;
    run_mode_e                 mode_q, mode_d;
    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic                      cpu_en_q, cpu_en_d;
    logic [7:0]                step_count_q, step_count_d;

    logic                      mode_chg_s;
    logic                      btn_rise_s;
    logic [DIV_W-1:0]          div_last_s;

    // Two-flop synchronizer chains for all asynchronous inputs.
    always_comb begin
        mode_s1_d = mode;
        mode_s2_d = mode_s1_q;
        in_s1_d   = {step_btn, sw_raw};
        in_s2_d   = in_s1_q;
    end

    // Per-bit debounce: output follows input only after a full run of disagreement.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < NDB; i++) begin
            if (in_s2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = {DB_W{1'b0}};
            end else if (deb_cnt_q[i] == DB_LAST) begin
                deb_d[i]     = in_s2_q[i];
                deb_cnt_d[i] = {DB_W{1'b0}};
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Run control: mode tracking, prescaler, step edge and pulse counter.
    always_comb begin
        mode_chg_s   = (mode_s2_q != mode_q);
        btn_rise_s   = deb_q[4] & ~btn_prev_q;
        mode_d       = run_mode_e'(mode_s2_q);
        btn_prev_d   = deb_q[4];
        div_cnt_d    = {DIV_W{1'b0}};
        cpu_en_d     = 1'b0;
        step_count_d = step_count_q + {7'd0, cpu_en_q};

        case (mode_q)
            MODE_SLOW: div_last_s = SLOW_LAST;
            MODE_FAST: div_last_s = FAST_LAST;
            default:   div_last_s = {DIV_W{1'b0}};
        endcase

        // A mode change restarts the prescaler phase and swallows any pulse,
        // including a terminal count or step edge landing on the same cycle.
        if (mode_chg_s) begin
            div_cnt_d = {DIV_W{1'b0}};
            cpu_en_d  = 1'b0;
        end else begin
            case (mode_q)
                MODE_SLOW, MODE_FAST: begin
                    if (div_cnt_q == div_last_s) begin
                        div_cnt_d = {DIV_W{1'b0}};
                        cpu_en_d  = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                        cpu_en_d  = 1'b0;
                    end
                end
                MODE_STEP: begin
                    cpu_en_d = btn_rise_s;
                end
                default: begin
                    cpu_en_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_s1_q    <= 2'b00;
            mode_s2_q    <= 2'b00;
            in_s1_q      <= {NDB{1'b0}};
            in_s2_q      <= {NDB{1'b0}};
            deb_q        <= {NDB{1'b0}};
            deb_cnt_q    <= '0;
            btn_prev_q   <= 1'b0;
            mode_q       <= MODE_HALT;
            div_cnt_q    <= {DIV_W{1'b0}};
            cpu_en_q     <= 1'b0;
            step_count_q <= 8'd0;
        end else begin
            mode_s1_q    <= mode_s1_d;
            mode_s2_q    <= mode_s2_d;
            in_s1_q      <= in_s1_d;
            in_s2_q      <= in_s2_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            btn_prev_q   <= btn_prev_d;
            mode_q       <= mode_d;
            div_cnt_q    <= div_cnt_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign sw         = deb_q[3:0];
    assign step_count = step_count_q;

endmodule

// File: tb/tb_td4_clock_ctrl.sv
// Directed bench for td4_clock_ctrl with DEBOUNCE_CYCLES=4, DIV_SLOW=10, DIV_FAST=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "tick t" below means the t-th rising edge after the last stimulus change.
module tb_td4_clock_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       step_btn;
    logic [3:0] sw_raw;
    logic       cpu_en;
    logic [3:0] sw;
    logic [7:0] step_count;

    int checks   = 0;
    int failures = 0;

    td4_clock_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DIV_SLOW       (10),
        .DIV_FAST       (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .step_btn  (step_btn),
        .sw_raw    (sw_raw),
        .cpu_en    (cpu_en),
        .sw        (sw),
        .step_count(step_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        mode     = 2'b00;
        step_btn = 1'b0;
        sw_raw   = 4'h0;

        // 1. Reset held while inputs toggle: all outputs stay at reset values.
        for (int i = 0; i < 6; i++) begin
            mode     = i[1:0];
            step_btn = i[0];
            sw_raw   = i[3:0] ^ 4'hF;
            tick(1);
            chk("rst_cpu_en", 32'(cpu_en), 32'd0);
            chk("rst_sw", 32'(sw), 32'd0);
            chk("rst_count", 32'(step_count), 32'd0);
        end
        mode = 2'b00; step_btn = 1'b0; sw_raw = 4'h0;
        tick(3);
        reset = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick(1);
            chk("halt_idle", 32'(cpu_en), 32'd0);
        end
        chk("halt_count", 32'(step_count), 32'd0);

        // 2. Switch debounce: 3-cycle bounces never reach sw.
        for (int b = 0; b < 2; b++) begin
            sw_raw = 4'b1010;
            for (int t = 0; t < 3; t++) begin tick(1); chk("sw_bounce", 32'(sw), 32'd0); end
            sw_raw = 4'b0000;
            for (int t = 0; t < 3; t++) begin tick(1); chk("sw_bounce", 32'(sw), 32'd0); end
        end
        sw_raw = 4'b1010;
        tick(5);
        chk("sw_tick5", 32'(sw), 32'd0);
        tick(1);
        chk("sw_tick6", 32'(sw), 32'hA);

        // 3. Step mode: bouncy press yields one pulse 7 ticks after the stable rise.
        mode = 2'b01;
        for (int t = 0; t < 5; t++) begin tick(1); chk("step_idle", 32'(cpu_en), 32'd0); end
        step_btn = 1'b1; tick(1); chk("btn_bounce", 32'(cpu_en), 32'd0);
        tick(1); chk("btn_bounce", 32'(cpu_en), 32'd0);
        step_btn = 1'b0; tick(2); chk("btn_bounce", 32'(cpu_en), 32'd0);
        step_btn = 1'b1; tick(3); chk("btn_bounce", 32'(cpu_en), 32'd0);
        step_btn = 1'b0; tick(1); chk("btn_bounce", 32'(cpu_en), 32'd0);
        step_btn = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            tick(1);
            chk("step_press1", 32'(cpu_en), 32'(t == 7));
        end
        chk("step_count1", 32'(step_count), 32'd1);
        step_btn = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            chk("step_release", 32'(cpu_en), 32'd0);
        end
        step_btn = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            chk("step_press2", 32'(cpu_en), 32'(t == 7));
        end
        chk("step_count2", 32'(step_count), 32'd2);

        // 4. Slow mode from a fresh reset: mode seen at tick 3, pulses at 13,23,...
        reset = 1'b1; mode = 2'b10; step_btn = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int t = 1; t <= 53; t++) begin
            tick(1);
            chk("slow_period", 32'(cpu_en), 32'((t >= 13) && ((t - 13) % 10 == 0)));
        end
        tick(1);
        chk("slow_count5", 32'(step_count), 32'd5);
        // Prescaler reaches 9 at tick 62; the change into fast is seen on that cycle.
        for (int t = 55; t <= 60; t++) begin
            tick(1);
            chk("slow_tail", 32'(cpu_en), 32'd0);
        end
        mode = 2'b11;
        for (int t = 1; t <= 12; t++) begin
            tick(1);
            chk("fast_switch", 32'(cpu_en), 32'((t == 6) || (t == 9) || (t == 12)));
        end
        chk("fast_count", 32'(step_count), 32'd7);

        // 5. Wrap: 248 more pulses take the count from 8 through 255 to 0.
        for (int t = 1; t <= 744; t++) begin
            tick(1);
            chk("fast_period", 32'(cpu_en), 32'(t % 3 == 0));
        end
        chk("count_255", 32'(step_count), 32'd255);
        tick(1);
        chk("count_wrap", 32'(step_count), 32'd0);
        mode = 2'b00;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            chk("halt_stop", 32'(cpu_en), 32'(t == 2));
        end
        chk("halt_freeze", 32'(step_count), 32'd1);

        // 6. Reset while the prescaler sits at 7 and a switch change is mid-debounce.
        mode = 2'b10;
        for (int t = 1; t <= 7; t++) begin tick(1); chk("pre_rst", 32'(cpu_en), 32'd0); end
        sw_raw = 4'b0101;
        for (int t = 8; t <= 10; t++) begin tick(1); chk("pre_rst", 32'(cpu_en), 32'd0); end
        reset = 1'b1;
        tick(2);
        chk("mid_rst_sw", 32'(sw), 32'd0);
        chk("mid_rst_count", 32'(step_count), 32'd0);
        chk("mid_rst_en", 32'(cpu_en), 32'd0);
        reset = 1'b0;
        for (int t = 1; t <= 13; t++) begin
            tick(1);
            chk("post_rst_slow", 32'(cpu_en), 32'(t == 13));
            if (t == 5) chk("post_rst_sw5", 32'(sw), 32'd0);
            if (t == 6) chk("post_rst_sw6", 32'(sw), 32'h5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
